regfile_write_port: RTL and testbench

//  Write side of the 32x32 register file: accepts writeback requests over a valid/ready

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_write_port_if.sv | 23 ++
 rtl/regfile_write_port_decoder_5to32.sv | 12 +
 rtl/regfile_write_port.sv | 148 ++++++++++++++
 tb/tb_regfile_write_port.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, FIFO-entry layout and helpers for the register-file write port.
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int ADDR_W     = 5;
  localparam int PKG_DATA_W = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [PKG_DATA_W-1:0] data;
  } wr_entry_t;

  localparam int WR_ENTRY_W = $bits(wr_entry_t);

  // Clears the hard-zero register's bit from any per-register vector.
  function automatic logic [NUM_REGS-1:0] zero_mask();
    return ~(NUM_REGS'(1) << ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_write_port_if.sv
// Writeback request handshake: producer drives valid/addr/data, write port returns ready.
interface regfile_write_port_if #(
  parameter int DATA_W = 32
);
  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output wb_valid,
    output wb_addr,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_addr,
    input  wb_data,
    output wb_ready
  );
endinterface

// File: rtl/regfile_write_port_decoder_5to32.sv
// 5-bit address to 32-bit one-hot enable; all zeros when en is low.
module decoder_5to32
  import regfile_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  assign onehot = en ? (NUM_REGS'(1) << addr) : '0;

endmodule

// File: rtl/regfile_write_port.sv
// Register-file write side: 2-entry write FIFO, one-hot drain decode, 31 storage registers.
// Optional macro REGFILE_WR_BYPASS_EN lets a write into an empty, unheld FIFO land directly.
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  regfile_write_port_if.slave        wb,
  input  logic                       wr_hold,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        pend_mask,
  output logic [1:0]                 fifo_cnt
);

  logic [1:0]        cnt_q, cnt_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              ready;
  logic              accept;
  logic              push;
  logic              drain;
  logic              byp;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NUM_REGS-1:0] wr_onehot;
  logic [NUM_REGS-1:0] wr_we;

  logic [DEPTH-1:0]    ent_vld;
  logic [NUM_REGS-1:0] pend_oh [DEPTH];
  logic [NUM_REGS-1:0] pend_all;

  assign ready       = reset_n && (cnt_q != 2'(DEPTH));
  assign wb.wb_ready = ready;
  assign accept      = wb.wb_valid && ready;
  assign drain       = (cnt_q != 2'd0) && !wr_hold;

`ifdef REGFILE_WR_BYPASS_EN
  // Bypass only when nothing is queued, so FIFO ordering can never be violated.
  assign byp = accept && (cnt_q == 2'd0) && !wr_hold;
`else
  assign byp = 1'b0;
`endif

  assign push = accept && !byp;

  // Drain and bypass are mutually exclusive (bypass needs an empty FIFO), so one decoder serves both.
  assign wr_en   = drain || byp;
  assign wr_addr = byp ? wb.wb_addr : fifo_addr_q[head_q];
  assign wr_data = byp ? wb.wb_data : fifo_data_q[head_q];

  decoder_5to32 u_wr_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (wr_onehot)
  );

  assign wr_we = wr_onehot & zero_mask();

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push)  tail_d = ~tail_q;
    if (drain) head_d = ~head_q;
    case ({push, drain})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_addr_d[tail_q] = wb.wb_addr;
      fifo_data_d[tail_q] = wb.wb_data;
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_we[k]) regs_d[k] = wr_data;
    end
    regs_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      regs_q <= '{default: '0};
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      regs_q <= regs_d;
    end
  end

  // Entry payload needs no reset: validity comes solely from cnt/head.
  always_ff @(posedge clock) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && (head_q == 1'(i)));
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_pend
    decoder_5to32 u_pend_dec (
      .en     (ent_vld[i]),
      .addr   (fifo_addr_q[i]),
      .onehot (pend_oh[i])
    );
  end

  always_comb begin
    pend_all = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_all = pend_all | pend_oh[i];
    end
  end

  assign pend_mask = pend_all & zero_mask();
  assign fifo_cnt  = cnt_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: queue-based reference model checked every cycle plus directed cases.
module tb_regfile_write_port;

  localparam int DW = 32;

  logic           clock;
  logic           reset_n;
  logic           wr_hold;
  logic [32*DW-1:0] regs_flat;
  logic [31:0]    pend_mask;
  logic [1:0]     fifo_cnt;

  regfile_write_port_if #(.DATA_W(DW)) wb_if ();

  regfile_write_port #(.DATA_W(DW), .DEPTH(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wb        (wb_if.slave),
    .wr_hold   (wr_hold),
    .regs_flat (regs_flat),
    .pend_mask (pend_mask),
    .fifo_cnt  (fifo_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mregs [32];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          mon_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_of(input int k);
    return regs_flat[k*DW +: DW];
  endfunction

  // Reference model: compare state left by the last edge, then advance across the next edge.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [31:0] pm;
      logic        exp_rdy;
      int          bad;
      bit          acc, dr, byp;
      ent_t        e;
      if (!reset_n) begin
        q.delete();
        for (int k = 0; k < 32; k++) mregs[k] = '0;
      end
      pm = '0;
      foreach (q[i]) pm[q[i].a] = 1'b1;
      pm[0] = 1'b0;
      exp_rdy = reset_n && (q.size() < 2);
      chk("mon_fifo_cnt", 64'(fifo_cnt), 64'(q.size()));
      chk("mon_pend_mask", 64'(pend_mask), 64'(pm));
      chk("mon_wb_ready", 64'(wb_if.wb_ready), 64'(exp_rdy));
      bad = -1;
      for (int k = 0; k < 32; k++) if (reg_of(k) !== mregs[k]) bad = k;
      n_chk++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL mon_regs reg%0d actual=%0h required=%0h at %0t",
                 bad, reg_of(bad), mregs[bad], $time);
      end
      if (reset_n) begin
        acc = wb_if.wb_valid && (q.size() < 2);
        dr  = (q.size() != 0) && !wr_hold;
`ifdef REGFILE_WR_BYPASS_EN
        byp = acc && (q.size() == 0) && !wr_hold;
`else
        byp = 0;
`endif
        if (dr) begin
          e = q.pop_front();
          if (e.a != 5'd0) mregs[e.a] = e.d;
        end
        if (acc) begin
          e.a = wb_if.wb_addr;
          e.d = wb_if.wb_data;
          if (byp) begin
            if (e.a != 5'd0) mregs[e.a] = e.d;
          end else begin
            q.push_back(e);
          end
        end
      end
    end
  end

  // Drive one cycle of stimulus, then advance to just after the next rising edge.
  task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d, input logic h);
    wb_if.wb_valid = v;
    wb_if.wb_addr  = a;
    wb_if.wb_data  = d;
    wr_hold        = h;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n        = 1'b0;
    wb_if.wb_valid = 1'b0;
    wb_if.wb_addr  = '0;
    wb_if.wb_data  = '0;
    wr_hold        = 1'b0;
    mon_en         = 1;
    @(posedge clock); #1;
    chk("rst_ready_low", 64'(wb_if.wb_ready), 64'd0);
    chk("rst_cnt", 64'(fifo_cnt), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    chk("rst_release_ready", 64'(wb_if.wb_ready), 64'd1);

    // Bypass vs FIFO latency on an empty, unheld port
    cyc(1, 5'd9, 32'h55, 0);
`ifdef REGFILE_WR_BYPASS_EN
    chk("byp_reg9_at_accept", 64'(reg_of(9)), 64'h55);
    chk("byp_cnt_zero", 64'(fifo_cnt), 64'd0);
`else
    chk("fifo_reg9_not_yet", 64'(reg_of(9)), 64'd0);
    chk("fifo_cnt_one", 64'(fifo_cnt), 64'd1);
`endif
    cyc(0, 5'd0, 32'h0, 0);
    chk("reg9_final", 64'(reg_of(9)), 64'h55);

    // Single write
    cyc(1, 5'd5, 32'hDEADBEEF, 0);
    cyc(0, 5'd0, 32'h0, 0);
    chk("single_reg5", 64'(reg_of(5)), 64'hDEADBEEF);
    chk("single_pend_clear", 64'(pend_mask), 64'd0);

    // Fill under hold, then drain in order
    cyc(1, 5'd3, 32'd1, 1);
    cyc(1, 5'd4, 32'd2, 1);
    chk("full_cnt", 64'(fifo_cnt), 64'd2);
    chk("full_ready", 64'(wb_if.wb_ready), 64'd0);
    chk("full_pend", 64'(pend_mask), 64'h18);
    cyc(0, 5'd0, 32'h0, 1);
    chk("held_reg3", 64'(reg_of(3)), 64'd0);
    cyc(0, 5'd0, 32'h0, 0);
    chk("drain_reg3", 64'(reg_of(3)), 64'd1);
    chk("drain_reg4_pending", 64'(reg_of(4)), 64'd0);
    cyc(0, 5'd0, 32'h0, 0);
    chk("drain_reg4", 64'(reg_of(4)), 64'd2);

    // Same address, accept+drain at count 1
    cyc(1, 5'd7, 32'hA, 1);
    cyc(1, 5'd7, 32'hB, 0);
    chk("same_cnt_stays1", 64'(fifo_cnt), 64'd1);
    chk("same_reg7_first", 64'(reg_of(7)), 64'hA);
    cyc(0, 5'd0, 32'h0, 0);
    chk("same_reg7_last", 64'(reg_of(7)), 64'hB);

    // Hard-zero register
    cyc(1, 5'd0, 32'hFFFFFFFF, 1);
    chk("zero_cnt", 64'(fifo_cnt), 64'd1);
    chk("zero_pend", 64'(pend_mask), 64'd0);
    cyc(0, 5'd0, 32'h0, 0);
    chk("zero_reg0", 64'(reg_of(0)), 64'd0);
    chk("zero_drained", 64'(fifo_cnt), 64'd0);

    // Random traffic with the model checking every cycle
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 3) == 0));
      if (n == 200) begin
        wb_if.wb_valid = 1'b1;
        wb_if.wb_addr  = 5'd12;
        wr_hold        = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_cnt", 64'(fifo_cnt), 64'd0);
        chk("midrst_pend", 64'(pend_mask), 64'd0);
        chk("midrst_ready", 64'(wb_if.wb_ready), 64'd0);
        chk("midrst_regs", 64'(regs_flat == '0), 64'd1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        chk("midrst_release_ready", 64'(wb_if.wb_ready), 64'd1);
      end
    end

    cyc(0, 5'd0, 32'h0, 0);
    cyc(0, 5'd0, 32'h0, 0);
    cyc(0, 5'd0, 32'h0, 0);
    @(negedge clock);
    #1;
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
